// File: rtl/cnn_pkg.sv
// Shared CNN datapath constants and the kernel_buffer sequencer state type.
// Optional KBUF_ZERO_FLAG_EN adds a per-kernel all-zero flag in kernel_buffer.
package cnn_pkg;

  localparam int WEIGHT_WIDTH = 8;
  localparam int KERNEL_SIZE  = 9;
  localparam int CH_W         = 8;

  typedef enum logic [1:0] {
    KB_IDLE  = 2'd0,
    KB_REQ   = 2'd1,
    KB_RECV  = 2'd2,
    KB_DRAIN = 2'd3
  } kbuf_state_e;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/kernel_bank.sv
// One ping-pong bank: weight register file, full flag and kernel tag.
// KBUF_ZERO_FLAG_EN adds the stored all-zero flag.
module kernel_bank
  import cnn_pkg::*;
#(
  parameter int WW = cnn_pkg::WEIGHT_WIDTH,
  parameter int KS = cnn_pkg::KERNEL_SIZE,
  parameter int IW = cnn_pkg::idx_w(cnn_pkg::KERNEL_SIZE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [IW-1:0]    wr_idx_i,
  input  logic [WW-1:0]    wr_data_i,
  input  logic             wr_fin_i,
  input  logic [CH_W-1:0]  tag_in_i,
  input  logic [CH_W-1:0]  tag_out_i,
  input  logic             last_i,
  input  logic             clr_i,
  output logic [WW*KS-1:0] data_o,
  output logic             full_o,
  output logic [CH_W-1:0]  tag_in_o,
  output logic [CH_W-1:0]  tag_out_o,
  output logic             last_o
`ifdef KBUF_ZERO_FLAG_EN
  ,
  output logic             zero_o
`endif
);

  logic [KS-1:0][WW-1:0] mem_q;
  logic                  full_q;
  logic [CH_W-1:0]       tag_in_q;
  logic [CH_W-1:0]       tag_out_q;
  logic                  last_q;
  logic                  fin;

  assign fin = wr_en_i & wr_fin_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q     <= '0;
      full_q    <= 1'b0;
      tag_in_q  <= '0;
      tag_out_q <= '0;
      last_q    <= 1'b0;
    end else begin
      if (wr_en_i) mem_q[wr_idx_i] <= wr_data_i;
      if (fin) begin
        tag_in_q  <= tag_in_i;
        tag_out_q <= tag_out_i;
        last_q    <= last_i;
      end
      // set and clear never coincide: writer and reader own different banks
      if (fin) full_q <= 1'b1;
      else if (clr_i) full_q <= 1'b0;
    end
  end

  assign data_o    = mem_q;
  assign full_o    = full_q;
  assign tag_in_o  = tag_in_q;
  assign tag_out_o = tag_out_q;
  assign last_o    = last_q;

`ifdef KBUF_ZERO_FLAG_EN
  logic nz_q;
  logic zero_q;
  logic nz_now;

  assign nz_now = nz_q | (|wr_data_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nz_q   <= 1'b0;
      zero_q <= 1'b0;
    end else if (wr_en_i) begin
      if (wr_fin_i) begin
        zero_q <= ~nz_now;
        nz_q   <= 1'b0;
      end else begin
        nz_q   <= nz_now;
      end
    end
  end

  assign zero_o = zero_q;
`endif

endmodule

// File: rtl/kernel_buffer.sv
// Kernel fetch sequencer and ping-pong collector for the conv engine.
// KBUF_ZERO_FLAG_EN adds the kernel_zero output.
module kernel_buffer #(
  parameter int WEIGHT_WIDTH = cnn_pkg::WEIGHT_WIDTH,
  parameter int KERNEL_SIZE  = cnn_pkg::KERNEL_SIZE
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            go,
  input  logic [7:0]                      num_in_ch,
  input  logic [7:0]                      num_out_ch,
  output logic                            busy,
  output logic                            done,
  output logic                            fetch_start,
  output logic [7:0]                      fetch_in_ch,
  output logic [7:0]                      fetch_out_ch,
  input  logic [WEIGHT_WIDTH-1:0]         w_data,
  input  logic                            w_valid,
  output logic                            w_ready,
  output logic [WEIGHT_WIDTH*KERNEL_SIZE-1:0] kernel_data,
  output logic [7:0]                      kernel_in_ch,
  output logic [7:0]                      kernel_out_ch,
  output logic                            kernel_last,
  output logic                            kernel_valid,
  input  logic                            kernel_ready
`ifdef KBUF_ZERO_FLAG_EN
  ,
  output logic                            kernel_zero
`endif
);

  import cnn_pkg::*;

  localparam int IW = idx_w(KERNEL_SIZE);
  localparam int DW = WEIGHT_WIDTH * KERNEL_SIZE;

  kbuf_state_e state_q, state_d;
  logic [7:0]  num_in_q, num_in_d;
  logic [7:0]  num_out_q, num_out_d;
  logic [7:0]  in_cnt_q, in_cnt_d;
  logic [7:0]  out_cnt_q, out_cnt_d;
  logic        wr_bank_q, wr_bank_d;
  logic        rd_bank_q, rd_bank_d;
  logic [IW-1:0] w_idx_q, w_idx_d;

  logic w_hs, w_fin, k_hs, in_wrap, is_last;

  logic [1:0][DW-1:0]   b_data;
  logic [1:0]           b_full;
  logic [1:0][7:0]      b_tin;
  logic [1:0][7:0]      b_tout;
  logic [1:0]           b_last;

  assign busy         = (state_q != KB_IDLE);
  assign w_ready      = (state_q == KB_RECV);
  assign fetch_start  = (state_q == KB_REQ) && !b_full[wr_bank_q];
  assign fetch_in_ch  = in_cnt_q;
  assign fetch_out_ch = out_cnt_q;

  assign w_hs    = w_valid & w_ready;
  assign w_fin   = w_hs && (w_idx_q == IW'(KERNEL_SIZE - 1));
  assign in_wrap = (in_cnt_q == num_in_q - 8'd1);
  assign is_last = in_wrap && (out_cnt_q == num_out_q - 8'd1);

  assign kernel_valid  = b_full[rd_bank_q];
  assign kernel_data   = b_data[rd_bank_q];
  assign kernel_in_ch  = b_tin[rd_bank_q];
  assign kernel_out_ch = b_tout[rd_bank_q];
  assign kernel_last   = b_last[rd_bank_q];

  assign k_hs = kernel_valid & kernel_ready;
  assign done = (state_q == KB_DRAIN) && k_hs && kernel_last;

  always_comb begin
    state_d   = state_q;
    num_in_d  = num_in_q;
    num_out_d = num_out_q;
    in_cnt_d  = in_cnt_q;
    out_cnt_d = out_cnt_q;
    wr_bank_d = wr_bank_q;
    w_idx_d   = w_idx_q;
    rd_bank_d = k_hs ? ~rd_bank_q : rd_bank_q;
    unique case (state_q)
      KB_IDLE: begin
        if (go && (num_in_ch != 8'd0) && (num_out_ch != 8'd0)) begin
          num_in_d  = num_in_ch;
          num_out_d = num_out_ch;
          in_cnt_d  = 8'd0;
          out_cnt_d = 8'd0;
          state_d   = KB_REQ;
        end
      end
      KB_REQ: begin
        if (fetch_start) state_d = KB_RECV;
      end
      KB_RECV: begin
        if (w_hs) w_idx_d = w_idx_q + IW'(1);
        if (w_fin) begin
          w_idx_d   = '0;
          wr_bank_d = ~wr_bank_q;
          if (in_wrap) begin
            in_cnt_d  = 8'd0;
            out_cnt_d = out_cnt_q + 8'd1;
          end else begin
            in_cnt_d  = in_cnt_q + 8'd1;
          end
          state_d = is_last ? KB_DRAIN : KB_REQ;
        end
      end
      KB_DRAIN: begin
        if (done) state_d = KB_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= KB_IDLE;
      num_in_q  <= '0;
      num_out_q <= '0;
      in_cnt_q  <= '0;
      out_cnt_q <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      w_idx_q   <= '0;
    end else begin
      state_q   <= state_d;
      num_in_q  <= num_in_d;
      num_out_q <= num_out_d;
      in_cnt_q  <= in_cnt_d;
      out_cnt_q <= out_cnt_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      w_idx_q   <= w_idx_d;
    end
  end

`ifdef KBUF_ZERO_FLAG_EN
  logic [1:0] b_zero;
  assign kernel_zero = b_zero[rd_bank_q];
`endif

  for (genvar b = 0; b < 2; b++) begin : g_bank
    kernel_bank #(
      .WW(WEIGHT_WIDTH),
      .KS(KERNEL_SIZE),
      .IW(IW)
    ) u_bank (
      .clk       (clk),
      .rst       (rst),
      .wr_en_i   (w_hs && (wr_bank_q == 1'(b))),
      .wr_idx_i  (w_idx_q),
      .wr_data_i (w_data),
      .wr_fin_i  (w_fin),
      .tag_in_i  (in_cnt_q),
      .tag_out_i (out_cnt_q),
      .last_i    (is_last),
      .clr_i     (k_hs && (rd_bank_q == 1'(b))),
      .data_o    (b_data[b]),
      .full_o    (b_full[b]),
      .tag_in_o  (b_tin[b]),
      .tag_out_o (b_tout[b]),
      .last_o    (b_last[b])
`ifdef KBUF_ZERO_FLAG_EN
      ,
      .zero_o    (b_zero[b])
`endif
    );
  end

endmodule

// File: tb/tb_kernel_buffer.sv
// Directed bench for kernel_buffer with a behavioural weight reader.
// Define KBUF_ZERO_FLAG_EN to also exercise kernel_zero.
module tb_kernel_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        go = 1'b0;
  logic [7:0]  num_in_ch = '0;
  logic [7:0]  num_out_ch = '0;
  logic        busy, done, fetch_start;
  logic [7:0]  fetch_in_ch, fetch_out_ch;
  logic [7:0]  w_data = '0;
  logic        w_valid = 1'b0;
  logic        w_ready;
  logic [71:0] kernel_data;
  logic [7:0]  kernel_in_ch, kernel_out_ch;
  logic        kernel_last, kernel_valid;
  logic        kernel_ready = 1'b0;
`ifdef KBUF_ZERO_FLAG_EN
  logic        kernel_zero;
`endif

  kernel_buffer dut (
    .clk           (clk),
    .rst           (rst),
    .go            (go),
    .num_in_ch     (num_in_ch),
    .num_out_ch    (num_out_ch),
    .busy          (busy),
    .done          (done),
    .fetch_start   (fetch_start),
    .fetch_in_ch   (fetch_in_ch),
    .fetch_out_ch  (fetch_out_ch),
    .w_data        (w_data),
    .w_valid       (w_valid),
    .w_ready       (w_ready),
    .kernel_data   (kernel_data),
    .kernel_in_ch  (kernel_in_ch),
    .kernel_out_ch (kernel_out_ch),
    .kernel_last   (kernel_last),
    .kernel_valid  (kernel_valid),
    .kernel_ready  (kernel_ready)
`ifdef KBUF_ZERO_FLAG_EN
    ,
    .kernel_zero   (kernel_zero)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [71:0] d;
    logic [7:0]  ic;
    logic [7:0]  oc;
    logic        last;
    logic        z;
  } kent_t;

  kent_t       kq[$];
  logic [15:0] fq[$];
  int          done_cnt = 0;
  int          beat_cnt = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  // weight reader model: 9 beats per fetch, starting the cycle after it
  int          rd_rem = 0;
  logic [7:0]  rd_next = 8'd1;
  bit          gap_mode = 0;
  bit          gap_phase = 0;
  bit          use_tab = 0;
  logic [7:0]  tab [0:31];

  always @(posedge clk) begin
    if (rst) begin
      rd_rem = 0;
    end else begin
      if (w_valid && w_ready) begin
        rd_next  = rd_next + 8'd1;
        rd_rem   = rd_rem - 1;
        beat_cnt = beat_cnt + 1;
      end
      if (fetch_start) begin
        rd_rem = rd_rem + 9;
        fq.push_back({fetch_out_ch, fetch_in_ch});
      end
      if (kernel_valid && kernel_ready) begin
        kent_t e;
        e.d    = kernel_data;
        e.ic   = kernel_in_ch;
        e.oc   = kernel_out_ch;
        e.last = kernel_last;
`ifdef KBUF_ZERO_FLAG_EN
        e.z    = kernel_zero;
`else
        e.z    = 1'b0;
`endif
        kq.push_back(e);
      end
      if (done) done_cnt = done_cnt + 1;
    end
  end

  always @(negedge clk) begin
    gap_phase = ~gap_phase;
    w_valid   = (rd_rem > 0) && (!gap_mode || gap_phase);
    w_data    = use_tab ? tab[rd_next[4:0]] : rd_next;
  end

  function automatic logic [71:0] kexp(input int base);
    logic [71:0] v;
    v = '0;
    for (int k = 0; k < 9; k++) v[k*8 +: 8] = 8'(base + k);
    return v;
  endfunction

  task automatic clear_logs();
    kq.delete();
    fq.delete();
    done_cnt = 0;
    beat_cnt = 0;
  endtask

  task automatic pulse_go(input logic [7:0] ni, input logic [7:0] no);
    @(negedge clk);
    num_in_ch  = ni;
    num_out_ch = no;
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int start;
    start = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_cnt != start) break;
    end
    n_vec++;
    if (done_cnt == start) begin
      n_bad++;
      $display("FAIL %s_timeout: no done within %0d cycles", tag, budget);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy got %b want 0", busy); end
    n_vec++; if (kernel_valid !== 1'b0) begin n_bad++; $display("FAIL rst_kvalid got %b want 0", kernel_valid); end
    n_vec++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL rst_wready got %b want 0", w_ready); end
    n_vec++; if (fetch_start !== 1'b0) begin n_bad++; $display("FAIL rst_fetch got %b want 0", fetch_start); end
    n_vec++; if (done !== 1'b0) begin n_bad++; $display("FAIL rst_done got %b want 0", done); end
    n_vec++; if (kernel_data !== 72'h0) begin n_bad++; $display("FAIL rst_kdata got %h want 0", kernel_data); end
    rst = 1'b0;
    kernel_ready = 1'b1;
    rd_next = 8'd1;
    clear_logs();
    pulse_go(8'd2, 8'd1);
    for (int i = 0; i < 50 && beat_cnt < 4; i++) @(negedge clk);
    rst = 1'b1;
    #1;
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL midrst_busy got %b want 0", busy); end
    n_vec++; if (kernel_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_kvalid got %b want 0", kernel_valid); end
    n_vec++; if (w_ready !== 1'b0) begin n_bad++; $display("FAIL midrst_wready got %b want 0", w_ready); end
    @(negedge clk);
    rst = 1'b0;
    clear_logs();
    rd_next = 8'd40;
    pulse_go(8'd1, 8'd1);
    wait_done(60, "restart");
    n_vec++; if (fq.size() !== 1) begin n_bad++; $display("FAIL restart_nfetch got %0d want 1", fq.size()); end
    n_vec++; if (fq.size() > 0 && fq[0] !== 16'h0000) begin n_bad++; $display("FAIL restart_ftag got %h want 0000", fq[0]); end
    n_vec++;
    if (kq.size() != 1 || kq[0].ic !== 8'd0 || kq[0].oc !== 8'd0 || kq[0].last !== 1'b1 || kq[0].d !== kexp(40)) begin
      n_bad++; $display("FAIL restart_kernel got n=%0d want one kernel (0,0) last=1", kq.size());
    end
  endtask

  task automatic test_basic();
    clear_logs();
    rd_next = 8'd1;
    kernel_ready = 1'b1;
    pulse_go(8'd2, 8'd1);
    wait_done(80, "basic");
    @(negedge clk);
    n_vec++; if (kq.size() !== 2) begin n_bad++; $display("FAIL basic_nk got %0d want 2", kq.size()); end
    if (kq.size() == 2) begin
      n_vec++; if (kq[0].d !== kexp(1)) begin n_bad++; $display("FAIL basic_k0 got %h want %h", kq[0].d, kexp(1)); end
      n_vec++; if ({kq[0].oc, kq[0].ic, kq[0].last} !== {8'd0, 8'd0, 1'b0}) begin n_bad++; $display("FAIL basic_t0 got %0d,%0d,%b want 0,0,0", kq[0].ic, kq[0].oc, kq[0].last); end
      n_vec++; if (kq[1].d !== kexp(10)) begin n_bad++; $display("FAIL basic_k1 got %h want %h", kq[1].d, kexp(10)); end
      n_vec++; if ({kq[1].oc, kq[1].ic, kq[1].last} !== {8'd0, 8'd1, 1'b1}) begin n_bad++; $display("FAIL basic_t1 got %0d,%0d,%b want 1,0,1", kq[1].ic, kq[1].oc, kq[1].last); end
    end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL basic_done got %0d want 1", done_cnt); end
    n_vec++; if (fq.size() != 2 || fq[0] !== 16'h0000 || fq[1] !== 16'h0001) begin n_bad++; $display("FAIL basic_fetch got n=%0d want (0,0),(1,0)", fq.size()); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL basic_idle got busy=%b want 0", busy); end
  endtask

  task automatic test_stall();
    clear_logs();
    rd_next = 8'd1;
    kernel_ready = 1'b0;
    pulse_go(8'd3, 8'd2);
    repeat (40) @(negedge clk);
    n_vec++; if (fq.size() !== 2) begin n_bad++; $display("FAIL stall_nfetch got %0d want 2", fq.size()); end
    n_vec++; if ({busy, fetch_start, w_ready} !== 3'b100) begin n_bad++; $display("FAIL stall_req got busy,fs,wr=%b%b%b want 100", busy, fetch_start, w_ready); end
    n_vec++; if (kernel_valid !== 1'b1) begin n_bad++; $display("FAIL stall_kvalid got %b want 1", kernel_valid); end
    n_vec++; if (kernel_data !== kexp(1)) begin n_bad++; $display("FAIL stall_kdata got %h want %h", kernel_data, kexp(1)); end
    n_vec++; if (kq.size() !== 0) begin n_bad++; $display("FAIL stall_noaccept got %0d want 0", kq.size()); end
    kernel_ready = 1'b1;
    wait_done(200, "stall");
    @(negedge clk);
    n_vec++; if (kq.size() !== 6) begin n_bad++; $display("FAIL stall_nk got %0d want 6", kq.size()); end
    for (int i = 0; i < 6 && i < kq.size(); i++) begin
      n_vec++;
      if (kq[i].ic !== 8'(i % 3) || kq[i].oc !== 8'(i / 3) || kq[i].last !== (i == 5) || kq[i].d !== kexp(1 + 9 * i)) begin
        n_bad++;
        $display("FAIL stall_k%0d got (%0d,%0d) last=%b d=%h want (%0d,%0d) last=%b d=%h",
                 i, kq[i].ic, kq[i].oc, kq[i].last, kq[i].d, i % 3, i / 3, (i == 5), kexp(1 + 9 * i));
      end
    end
    n_vec++; if (done_cnt !== 1) begin n_bad++; $display("FAIL stall_done got %0d want 1", done_cnt); end
  endtask

  task automatic test_gap();
    clear_logs();
    rd_next = 8'd1;
    gap_mode = 1;
    kernel_ready = 1'b1;
    pulse_go(8'd2, 8'd1);
    wait_done(120, "gap");
    @(negedge clk);
    gap_mode = 0;
    n_vec++; if (kq.size() !== 2) begin n_bad++; $display("FAIL gap_nk got %0d want 2", kq.size()); end
    if (kq.size() == 2) begin
      n_vec++; if (kq[0].d !== kexp(1)) begin n_bad++; $display("FAIL gap_k0 got %h want %h", kq[0].d, kexp(1)); end
      n_vec++; if (kq[1].d !== kexp(10)) begin n_bad++; $display("FAIL gap_k1 got %h want %h", kq[1].d, kexp(10)); end
    end
  endtask

  task automatic test_ignore_go();
    clear_logs();
    rd_next = 8'd1;
    kernel_ready = 1'b1;
    pulse_go(8'd0, 8'd3);
    repeat (5) @(negedge clk);
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL zgo_busy got %b want 0", busy); end
    n_vec++; if (fq.size() !== 0) begin n_bad++; $display("FAIL zgo_fetch got %0d want 0", fq.size()); end
    n_vec++; if (done_cnt !== 0) begin n_bad++; $display("FAIL zgo_done got %0d want 0", done_cnt); end
    pulse_go(8'd2, 8'd1);
    repeat (3) @(negedge clk);
    pulse_go(8'd3, 8'd3);
    wait_done(80, "busygo");
    repeat (3) @(negedge clk);
    n_vec++; if (kq.size() !== 2) begin n_bad++; $display("FAIL busygo_nk got %0d want 2", kq.size()); end
    n_vec++;
    if (kq.size() != 2 || kq[1].ic !== 8'd1 || kq[1].oc !== 8'd0 || kq[1].last !== 1'b1) begin
      n_bad++; $display("FAIL busygo_last got n=%0d want 2nd kernel (1,0) last=1", kq.size());
    end
    n_vec++; if (fq.size() !== 2) begin n_bad++; $display("FAIL busygo_nfetch got %0d want 2", fq.size()); end
    n_vec++; if (busy !== 1'b0) begin n_bad++; $display("FAIL busygo_idle got busy=%b want 0", busy); end
  endtask

`ifdef KBUF_ZERO_FLAG_EN
  task automatic test_zero_flag();
    clear_logs();
    for (int i = 0; i < 32; i++) tab[i] = 8'h00;
    tab[17] = 8'h05;
    use_tab = 1;
    rd_next = 8'd0;
    kernel_ready = 1'b1;
    pulse_go(8'd2, 8'd1);
    wait_done(80, "zero");
    @(negedge clk);
    use_tab = 0;
    n_vec++; if (kq.size() != 2 || kq[0].z !== 1'b1) begin n_bad++; $display("FAIL zero_all got n=%0d want kernel_zero=1", kq.size()); end
    n_vec++; if (kq.size() != 2 || kq[1].z !== 1'b0) begin n_bad++; $display("FAIL zero_w8 got n=%0d want kernel_zero=0", kq.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_gap();
    test_ignore_go();
`ifdef KBUF_ZERO_FLAG_EN
    test_zero_flag();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/kernel_buffer.md
# kernel_buffer

Sequencer and ping-pong collector sitting directly downstream of the weight ROM reader. It walks a programmed (out_ch, in_ch) grid and issues one fetch per kernel to the weight reader. It assembles each serial 9-weight stream into a parallel kernel word and presents it to the convolution engine with a valid/ready handshake. Two banks let the next kernel load while the engine holds the current one.

## Interface
- WEIGHT_WIDTH, 8, bits per weight
- KERNEL_SIZE, 9, weights per kernel
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- go  in  1  start pulse; sampled only in IDLE
- num_in_ch  in  8  input channels to walk, sampled at go
- num_out_ch  in  8  output channels to walk, sampled at go
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse when the last kernel is consumed
- fetch_start  out  1  request to the weight reader, one cycle
- fetch_in_ch  out  8  in_ch for the request
- fetch_out_ch  out  8  out_ch for the request
- w_data  in  WEIGHT_WIDTH  weight from the reader
- w_valid  in  1  weight valid
- w_ready  out  1  weight accepted
- kernel_data  out  WEIGHT_WIDTH*KERNEL_SIZE  weight k at [k*WEIGHT_WIDTH +: WEIGHT_WIDTH], k=0 first received
- kernel_in_ch, kernel_out_ch  out  8  tag of the presented kernel
- kernel_last  out  1  presented kernel is the final one of the walk
- kernel_valid  out  1  kernel available
- kernel_ready  in  1  consumer accepts

## Operation
- States: IDLE, REQ, RECV, DRAIN.
- IDLE:
  - go with both counts non-zero latches the counts, clears in_cnt/out_cnt, and moves to REQ.
  - go with either count zero is ignored.
- REQ:
  - If bank[wr_bank] is not full, fetch_start=1 (combinational) with fetch_in_ch=in_cnt and fetch_out_ch=out_cnt, then move to RECV.
  - Otherwise stall in REQ with fetch_start=0.
- RECV:
  - w_ready=1. Each w_valid&&w_ready writes w_data to bank[wr_bank][w_idx] and increments w_idx.
  - On the handshake at w_idx==KERNEL_SIZE-1: set full[wr_bank], store the tag and last flag, toggle wr_bank, clear w_idx.
  - Advance in_cnt (inner loop), wrapping to 0 and incrementing out_cnt.
  - Go to DRAIN if this kernel was last, else to REQ.
- DRAIN: wait. On the consumer handshake of the kernel with kernel_last=1, pulse done and go to IDLE.
- Output side:
  - kernel_valid=full[rd_bank]; kernel_data and tags come from bank[rd_bank].
  - kernel_valid&&kernel_ready clears full[rd_bank] and toggles rd_bank.
- Same-cycle set of full[wr_bank] and clear of full[rd_bank] is legal; they are always different banks.
- w_ready=0 outside RECV. Weights offered then are not accepted.
- go while busy is ignored.

## Timing
- Reset values:
  - All outputs 0.
  - State IDLE; wr_bank, rd_bank, w_idx, counters 0; both full flags 0.
  - Bank contents are don't-care but reset to 0.
- go at edge T → REQ in cycle T+1, and fetch_start is high in that cycle if a bank is free.
- The reader's first weight arrives one cycle after fetch_start.
- With w_valid and kernel_ready held high, there is one kernel per KERNEL_SIZE+1 cycles.
- kernel_valid rises in the cycle after the final weight handshake.
- kernel_valid is held, and kernel_data and tags are stable, until accepted.
- Consumer stall: at most two kernels buffered. The third fetch waits in REQ.
- Reset mid-walk returns to IDLE immediately and drops kernel_valid. The weight reader shares rst, so no stale stream survives.

## Configuration
- KBUF_ZERO_FLAG_EN defined:
  - Adds output kernel_zero (1 bit), stored per bank. It is set when all KERNEL_SIZE weights of the kernel are zero, so the conv engine can skip the MAC.
  - It is computed incrementally with an OR-accumulator during RECV.
- Not defined: the port and logic are absent.

## Structure
- Shared package cnn_pkg holds:
  - WEIGHT_WIDTH and KERNEL_SIZE defaults.
  - The kbuf state enum (IDLE/REQ/RECV/DRAIN).
  - The channel index width (8).
- One sub-module, kernel_bank, instantiated twice: a KERNEL_SIZE×WEIGHT_WIDTH register file with a write index port, a full flag, a tag register and, under the macro, the zero flag.

## Test plan
- Reset during RECV after 4 weights → next cycle busy=0, kernel_valid=0, w_ready=0; a fresh go restarts at (0,0).
- num_in_ch=2, num_out_ch=1, weights 1..18, kernel_ready=1:
  - First kernel: kernel_data words 1..9, tag (0,0), kernel_last=0.
  - Second kernel: words 10..18, tag (1,0), kernel_last=1.
  - done pulses once.
- num_in_ch=3, num_out_ch=2, kernel_ready=0:
  - Exactly two fetch_start pulses, then stall in REQ.
  - Raising kernel_ready delivers six kernels in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1).
- w_valid toggling 1-0-1:
  - Only valid beats are captured.
  - kernel_data is identical to the no-gap run.
- go with num_in_ch=0 → stays IDLE, no fetch_start, no done. A second go while busy is ignored, and the counts are unchanged.
- KBUF_ZERO_FLAG_EN: an all-zero kernel gives kernel_zero=1; a kernel with only weight 8 non-zero gives kernel_zero=0.
